counter_10000_ctrl: RTL and testbench
=====================================

// Module: counter_10000_ctrl
// PURPOSE
//  Sits directly downstream of the 10 Hz tick generator and consumes its o_tick_10hz pulse.
//  Runs a 4-digit BCD counter (0..9999) with up/down mode under a run/stop/clear FSM.
//  Drives the generator's enable/clear inputs and presents BCD digits to the FND/UART-TX stages.
//  Accepts commands from button pulses and from received UART bytes.
// PARAMETERS
//  MAX_COUNT  9999  terminal value of the counter (wrap point); must be <= 9999
// PORTS
//  clk           in   1   system clock
//  rst           in   1   reset, asynchronous, active-high
//  i_tick        in   1   1-cycle count pulse from tick generator
//  i_btn_run     in   1   1-cycle pulse: toggle run/stop
//  i_btn_clear   in   1   1-cycle pulse: clear counter
//  i_btn_mode    in   1   1-cycle pulse: toggle up/down
//  i_rx_data     in   8   received UART byte
//  i_rx_valid    in   1   1-cycle strobe, i_rx_data valid
//  o_tick_en     out  1   enable to tick generator (1 in RUN)
//  o_tick_clr    out  1   clear to tick generator (1 in CLEAR)
//  o_bcd         out  16  {thousands,hundreds,tens,ones}, 4 bits each
//  o_running     out  1   1 when state == RUN
//  o_mode_down   out  1   0 = count up, 1 = count down
//  o_wrap        out  1   1-cycle pulse on wrap-around
// BEHAVIOUR
//  Reset: state=STOP, o_bcd=0, o_mode_down=0, o_wrap=0, o_tick_en=0, o_tick_clr=0.
//  Command decode (registered, 1 cycle): run = i_btn_run | (i_rx_valid & rx in {'R','r'});
//   clr = i_btn_clear | (rx in {'C','c'}); mode = i_btn_mode | (rx in {'M','m'}).
//   All other bytes are ignored. A button pulse and a matching byte in the same cycle act once.
//  FSM states: STOP, RUN, CLEAR.
//   STOP --run--> RUN; RUN --run--> STOP; any --clr--> CLEAR; CLEAR --(1 cycle)--> STOP.
//   Priority: clr > run. mode toggles o_mode_down in any state, independently of run/clr.
//  CLEAR: o_tick_clr=1 for exactly 1 cycle; o_bcd <= 0; mode is retained.
//  o_tick_en = (state==RUN); o_tick_clr = (state==CLEAR); both are decoded from the state register.
//  Counting: only in RUN; i_tick at edge N updates o_bcd at edge N (visible from cycle N+1).
//   Up:   each digit +1 with decimal carry; MAX_COUNT -> 0 and o_wrap=1 for 1 cycle.
//   Down: each digit -1 with decimal borrow; 0 -> MAX_COUNT and o_wrap=1 for 1 cycle.
//   Digits never leave 0..9. i_tick is ignored in STOP and CLEAR.
//  Simultaneous events: i_tick with clr -> clear wins and the tick is discarded.
//   i_tick with a run->STOP transition -> that tick is still counted.
//   Mode toggle with i_tick -> the tick uses the old direction.
//  Reset mid-count: all outputs return to reset values immediately, independent of clk.
// TESTING
//  T1 reset, run pulse, 12 ticks -> o_bcd=16'h0012, o_running=1, o_tick_en=1.
//  T2 preload to 9998 (up), 2 ticks -> 9999 then 0000, o_wrap high exactly 1 cycle on 2nd tick.
//  T3 from 0000, mode pulse, run, 1 tick -> o_bcd=16'h9999, o_wrap=1; 3 more ticks -> 9996.
//  T4 rx 'c' and i_tick in the same cycle at 0123 -> o_bcd=0, o_tick_clr=1 for 1 cycle,
//     then STOP; a following tick leaves 0.
//  T5 rx 'R', then 'x', then 'r' -> RUN, unchanged, STOP; ticks in STOP do not change o_bcd.
//  T6 assert rst while RUN at 0456 -> o_bcd=0, STOP, o_mode_down=0, with no clk edge needed.

Source files
------------

// File: rtl/counter_10000_ctrl.sv
// rtl/counter_10000_ctrl.sv - run/stop/clear controlled 4-digit BCD up/down counter
// Consumes the 10 Hz tick, decodes button and UART commands, drives the tick generator.
module counter_10000_ctrl #(
    parameter int MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tick,
    input  logic        i_btn_run,
    input  logic        i_btn_clear,
    input  logic        i_btn_mode,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_tick_en,
    output logic        o_tick_clr,
    output logic [15:0] o_bcd,
    output logic        o_running,
    output logic        o_mode_down,
    output logic        o_wrap
);

    localparam logic [15:0] MAX_BCD = {4'(MAX_COUNT / 1000 % 10), 4'(MAX_COUNT / 100 % 10),
                                       4'(MAX_COUNT / 10 % 10), 4'(MAX_COUNT % 10)};

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t      state;
    logic        run_q;
    logic        clr_q;
    logic        mode_q;
    logic        rx_run;
    logic        rx_clr;
    logic        rx_mode;
    logic        clr_now;
    logic        count_en;
    logic        wrap_hit;
    logic [15:0] next_bcd;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign rx_run  = i_rx_valid & ((i_rx_data == 8'h52) | (i_rx_data == 8'h72));
    assign rx_clr  = i_rx_valid & ((i_rx_data == 8'h43) | (i_rx_data == 8'h63));
    assign rx_mode = i_rx_valid & ((i_rx_data == 8'h4D) | (i_rx_data == 8'h6D));
    assign clr_now = i_btn_clear | rx_clr;

    // A clear seen on the inputs or pending in the decode stage swallows a concurrent tick.
    assign count_en = (state == RUN) & i_tick & ~clr_q & ~clr_now;

    always_comb begin
        next_bcd = o_bcd;
        wrap_hit = 1'b0;
        if (o_mode_down) begin
            if (o_bcd == 16'h0000) begin
                next_bcd = MAX_BCD;
                wrap_hit = 1'b1;
            end else begin
                next_bcd = bcd_dec(o_bcd);
            end
        end else begin
            if (o_bcd == MAX_BCD) begin
                next_bcd = 16'h0000;
                wrap_hit = 1'b1;
            end else begin
                next_bcd = bcd_inc(o_bcd);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= STOP;
            run_q       <= 1'b0;
            clr_q       <= 1'b0;
            mode_q      <= 1'b0;
            o_bcd       <= 16'h0000;
            o_mode_down <= 1'b0;
            o_wrap      <= 1'b0;
        end else begin
            run_q  <= i_btn_run | rx_run;
            clr_q  <= clr_now;
            mode_q <= i_btn_mode | rx_mode;

            if (mode_q) begin
                o_mode_down <= ~o_mode_down;
            end

            o_wrap <= count_en & wrap_hit;
            if (clr_q) begin
                o_bcd <= 16'h0000;
            end else if (count_en) begin
                o_bcd <= next_bcd;
            end

            if (clr_q) begin
                state <= CLEAR;
            end else begin
                case (state)
                    STOP:    state <= run_q ? RUN : STOP;
                    RUN:     state <= run_q ? STOP : RUN;
                    CLEAR:   state <= STOP;
                    default: state <= STOP;
                endcase
            end
        end
    end

    assign o_tick_en  = (state == RUN);
    assign o_tick_clr = (state == CLEAR);
    assign o_running  = (state == RUN);

endmodule

// File: tb/tb_counter_10000_ctrl.sv
// tb/tb_counter_10000_ctrl.sv - directed and randomized checks of counter_10000_ctrl
module tb_counter_10000_ctrl;

    localparam int MAX = 9999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        btn_run = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_mode = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tick_en;
    logic        tick_clr;
    logic [15:0] bcd;
    logic        running;
    logic        mode_down;
    logic        wrap;

    int checks = 0;
    int errors = 0;

    // Reference model: integer count, named state, commands delayed one cycle.
    int   m_count;
    int   m_state;   // 0 stop, 1 run, 2 clear
    bit   m_down;
    bit   m_wrap;
    bit   p_run, p_clr, p_mode;

    counter_10000_ctrl #(.MAX_COUNT(MAX)) dut (
        .clk(clk), .rst(rst), .i_tick(tick), .i_btn_run(btn_run),
        .i_btn_clear(btn_clear), .i_btn_mode(btn_mode), .i_rx_data(rx_data),
        .i_rx_valid(rx_valid), .o_tick_en(tick_en), .o_tick_clr(tick_clr),
        .o_bcd(bcd), .o_running(running), .o_mode_down(mode_down), .o_wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_count = 0; m_state = 0; m_down = 0; m_wrap = 0;
        p_run = 0; p_clr = 0; p_mode = 0;
    endtask

    task automatic model_step();
        bit c_run, c_clr, c_mode, tick_ok;
        c_run  = btn_run   || (rx_valid && (rx_data == "R" || rx_data == "r"));
        c_clr  = btn_clear || (rx_valid && (rx_data == "C" || rx_data == "c"));
        c_mode = btn_mode  || (rx_valid && (rx_data == "M" || rx_data == "m"));
        tick_ok = (m_state == 1) && tick && !c_clr && !p_clr;
        m_wrap = 0;
        if (p_clr) begin
            m_count = 0;
        end else if (tick_ok) begin
            if (m_down) begin
                if (m_count == 0) begin m_count = MAX; m_wrap = 1; end
                else m_count = m_count - 1;
            end else begin
                if (m_count == MAX) begin m_count = 0; m_wrap = 1; end
                else m_count = m_count + 1;
            end
        end
        if (p_clr) m_state = 2;
        else if (m_state == 2) m_state = 0;
        else if (p_run) m_state = (m_state == 1) ? 0 : 1;
        if (p_mode) m_down = !m_down;
        p_run = c_run; p_clr = c_clr; p_mode = c_mode;
    endtask

    // One clock: inputs applied from a negedge, model advanced at the posedge.
    task automatic step(input bit t, input bit r, input bit c, input bit m,
                        input bit v, input logic [7:0] d);
        tick = t; btn_run = r; btn_clear = c; btn_mode = m; rx_valid = v; rx_data = d;
        @(posedge clk);
        model_step();
        @(negedge clk);
        tick = 0; btn_run = 0; btn_clear = 0; btn_mode = 0; rx_valid = 0; rx_data = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bcd, running, tick_en, tick_clr, mode_down, wrap} !== 21'h0) begin
            errors++;
            $display("FAIL reset_state: bcd=%h run=%b en=%b clr=%b down=%b wrap=%b, required all 0",
                     bcd, running, tick_en, tick_clr, mode_down, wrap);
        end
    endtask

    task automatic test_count_up();
        do_reset();
        step(0, 1, 0, 0, 0, 8'h00);
        idle(1);
        ticks(12);
        checks++;
        if (bcd !== 16'h0012) begin
            errors++; $display("FAIL up12_bcd: got %h, required 0012", bcd);
        end
        checks++;
        if (running !== 1'b1 || tick_en !== 1'b1) begin
            errors++; $display("FAIL up12_run: running=%b tick_en=%b, required 1 1", running, tick_en);
        end
    endtask

    task automatic test_wrap_up();
        do_reset();
        step(0, 0, 0, 1, 0, 8'h00);
        step(0, 1, 0, 0, 0, 8'h00);
        idle(1);
        ticks(2);
        step(0, 0, 0, 1, 0, 8'h00);
        idle(1);
        checks++;
        if (bcd !== 16'h9998 || mode_down !== 1'b0) begin
            errors++; $display("FAIL preload: bcd=%h down=%b, required 9998 0", bcd, mode_down);
        end
        ticks(1);
        checks++;
        if (bcd !== 16'h9999 || wrap !== 1'b0) begin
            errors++; $display("FAIL up_9999: bcd=%h wrap=%b, required 9999 0", bcd, wrap);
        end
        ticks(1);
        checks++;
        if (bcd !== 16'h0000 || wrap !== 1'b1) begin
            errors++; $display("FAIL up_wrap: bcd=%h wrap=%b, required 0000 1", bcd, wrap);
        end
        idle(1);
        checks++;
        if (wrap !== 1'b0) begin
            errors++; $display("FAIL up_wrap_pulse: wrap=%b, required 0", wrap);
        end
    endtask

    task automatic test_count_down();
        do_reset();
        step(0, 0, 0, 1, 0, 8'h00);
        step(0, 1, 0, 0, 0, 8'h00);
        idle(1);
        ticks(1);
        checks++;
        if (bcd !== 16'h9999 || wrap !== 1'b1 || mode_down !== 1'b1) begin
            errors++; $display("FAIL down_wrap: bcd=%h wrap=%b down=%b, required 9999 1 1",
                               bcd, wrap, mode_down);
        end
        ticks(3);
        checks++;
        if (bcd !== 16'h9996 || wrap !== 1'b0) begin
            errors++; $display("FAIL down_9996: bcd=%h wrap=%b, required 9996 0", bcd, wrap);
        end
    endtask

    task automatic test_clear_vs_tick();
        do_reset();
        step(0, 1, 0, 0, 0, 8'h00);
        idle(1);
        ticks(123);
        step(1, 0, 0, 0, 1, "c");
        step(1, 0, 0, 0, 0, 8'h00);
        checks++;
        if (bcd !== 16'h0000 || tick_clr !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL clear_tick: bcd=%h clr=%b run=%b, required 0000 1 0",
                               bcd, tick_clr, running);
        end
        ticks(1);
        checks++;
        if (bcd !== 16'h0000 || tick_clr !== 1'b0 || running !== 1'b0) begin
            errors++; $display("FAIL clear_after: bcd=%h clr=%b run=%b, required 0000 0 0",
                               bcd, tick_clr, running);
        end
    endtask

    task automatic test_rx_commands();
        do_reset();
        step(0, 0, 0, 0, 1, "R");
        idle(1);
        checks++;
        if (running !== 1'b1) begin
            errors++; $display("FAIL rx_R: running=%b, required 1", running);
        end
        ticks(1);
        step(0, 0, 0, 0, 1, "x");
        idle(1);
        checks++;
        if (running !== 1'b1 || bcd !== 16'h0001) begin
            errors++; $display("FAIL rx_x: running=%b bcd=%h, required 1 0001", running, bcd);
        end
        step(0, 0, 0, 0, 1, "r");
        idle(1);
        ticks(3);
        checks++;
        if (running !== 1'b0 || bcd !== 16'h0001) begin
            errors++; $display("FAIL rx_r_stop: running=%b bcd=%h, required 0 0001", running, bcd);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(0, 1, 0, 0, 0, 8'h00);
        idle(1);
        ticks(456);
        checks++;
        if (bcd !== 16'h0456) begin
            errors++; $display("FAIL pre_rst: bcd=%h, required 0456", bcd);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bcd, running, tick_en, tick_clr, mode_down, wrap} !== 21'h0) begin
            errors++; $display("FAIL async_rst: bcd=%h run=%b en=%b down=%b, required all 0",
                               bcd, running, tick_en, mode_down);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [7:0] pick [7];
        pick = '{"R", "r", "C", "c", "M", "m", 8'h00};
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit t, r, c, m, v;
            logic [7:0] d;
            t = ($urandom_range(0, 2) != 0);
            r = ($urandom_range(0, 39) == 0);
            c = ($urandom_range(0, 299) == 0);
            m = ($urandom_range(0, 59) == 0);
            v = ($urandom_range(0, 9) == 0);
            d = pick[$urandom_range(0, 6)];
            if (d == 8'h00) d = 8'($urandom);
            if ((d == "C" || d == "c") && $urandom_range(0, 9) != 0) d = "q";
            step(t, r, c, m, v, d);
            checks++;
            if ({bcd, wrap, running, tick_en, tick_clr, mode_down} !==
                {to_bcd(m_count), m_wrap, m_state == 1, m_state == 1, m_state == 2, m_down}) begin
                errors++;
                $display("FAIL random[%0d]: bcd=%h wrap=%b run=%b clr=%b down=%b, required %h %b %b %b %b",
                         i, bcd, wrap, running, tick_clr, mode_down, to_bcd(m_count), m_wrap,
                         m_state == 1, m_state == 2, m_down);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_up();
        test_wrap_up();
        test_count_down();
        test_clear_vs_tick();
        test_rx_commands();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
